// File: rtl/huffman_pkg.sv
// Shared constants and types for the huffman_decoder stream controller.
package huffman_pkg;

   localparam int unsigned SYM_W        = 5;
   localparam int unsigned BYTE_W       = 8;
   localparam int unsigned MAX_CODE_LEN = 8;

   typedef logic [SYM_W-1:0] sym_t;

   typedef enum logic [2:0] {
      LOAD,
      SHIFT,
      CHECK,
      EMIT,
      CLEAR
   } ctrl_state_t;

endpackage

// File: rtl/huffman_bit_serializer.sv
// Byte-wide shift register that hands out bits MSB-first and tracks how many remain.
module huffman_bit_serializer
   import huffman_pkg::*;
#(
   parameter int unsigned ByteW = BYTE_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [ByteW-1:0] data_in,
   output logic             bit_out,
   output logic             empty
);

   localparam int unsigned CntW = $clog2(ByteW + 1);

   logic [ByteW-1:0] sh_q, sh_d;
   logic [CntW-1:0]  bits_left_q, bits_left_d;

   always_comb begin
      sh_d        = sh_q;
      bits_left_d = bits_left_q;
      if (load) begin
         sh_d        = data_in;
         bits_left_d = CntW'(ByteW);
      end else if (shift) begin
         sh_d        = sh_q << 1;
         bits_left_d = bits_left_q - CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_q        <= '0;
         bits_left_q <= '0;
      end else begin
         sh_q        <= sh_d;
         bits_left_q <= bits_left_d;
      end
   end

   assign bit_out = sh_q[ByteW-1];
   assign empty   = (bits_left_q == '0);

endmodule

// File: rtl/huffman_stream_ctrl.sv
// Feeds packed code bytes bit-serially into huffman_decoder and streams out decoded symbols.
// Define HUFF_CTRL_STATS_EN to add the sym_count / err_count statistics outputs.
module huffman_stream_ctrl
   import huffman_pkg::*;
#(
   parameter int unsigned SymW       = SYM_W,
   parameter int unsigned ByteW      = BYTE_W,
   parameter int unsigned MaxCodeLen = MAX_CODE_LEN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ByteW-1:0] byte_in,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic             dec_in,
   output logic             dec_en,
   output logic             dec_clr,
   input  logic [SymW-1:0]  dec_sx,
   input  logic             dec_flag,
   output logic [SymW-1:0]  sym_out,
   output logic             sym_valid,
   input  logic             sym_ready,
   output logic             err
`ifdef HUFF_CTRL_STATS_EN
   ,
   output logic [15:0]      sym_count,
   output logic [7:0]       err_count
`endif
);

   localparam int unsigned LenW = $clog2(MaxCodeLen + 1);

   ctrl_state_t     state_q, state_d;
   logic [LenW-1:0] code_len_q, code_len_d;
   logic [SymW-1:0] sym_q, sym_d;
   logic            sym_valid_q, sym_valid_d;
   logic            init_q;
   logic            sh_bit, sh_empty, sh_load, sh_shift;
   logic            code_full, sym_hs;

   huffman_bit_serializer #(
      .ByteW (ByteW)
   ) u_ser (
      .clk     (clk),
      .reset   (reset),
      .load    (sh_load),
      .shift   (sh_shift),
      .data_in (byte_in),
      .bit_out (sh_bit),
      .empty   (sh_empty)
   );

   assign code_full = (code_len_q == LenW'(MaxCodeLen));
   assign sh_load   = byte_valid && byte_ready;
   assign sh_shift  = (state_q == SHIFT);
   assign sym_hs    = (state_q == EMIT) && sym_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LOAD:    if (sh_load) state_d = SHIFT;
         SHIFT:   state_d = CHECK;
         CHECK: begin
            if (dec_flag)      state_d = EMIT;
            else if (code_full) state_d = CLEAR;
            else if (sh_empty)  state_d = LOAD;
            else                state_d = SHIFT;
         end
         EMIT:    if (sym_ready) state_d = CLEAR;
         CLEAR:   state_d = sh_empty ? LOAD : SHIFT;
         default: state_d = LOAD;
      endcase
   end

   // init_q holds the decoder in restart during reset and for the first edge after release.
   always_comb begin
      byte_ready = (state_q == LOAD) && !init_q;
      dec_en     = (state_q == SHIFT);
      dec_in     = (state_q == SHIFT) ? sh_bit : 1'b0;
      dec_clr    = init_q || (state_q == CLEAR);
      err        = (state_q == CHECK) && !dec_flag && code_full;
      sym_out    = sym_q;
      sym_valid  = sym_valid_q;
   end

   always_comb begin
      code_len_d  = code_len_q;
      sym_d       = sym_q;
      sym_valid_d = sym_valid_q;
      if (state_q == SHIFT) code_len_d = code_len_q + LenW'(1);
      if (state_q == CLEAR) code_len_d = '0;
      if ((state_q == CHECK) && dec_flag) begin
         sym_d       = dec_sx;
         sym_valid_d = 1'b1;
      end
      if (sym_hs) sym_valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         code_len_q  <= '0;
         sym_q       <= '0;
         sym_valid_q <= 1'b0;
         init_q      <= 1'b1;
      end else begin
         code_len_q  <= code_len_d;
         sym_q       <= sym_d;
         sym_valid_q <= sym_valid_d;
         init_q      <= 1'b0;
      end
   end

`ifdef HUFF_CTRL_STATS_EN
   logic [15:0] sym_count_q;
   logic [7:0]  err_count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sym_count_q <= '0;
         err_count_q <= '0;
      end else begin
         if (sym_hs) sym_count_q <= sym_count_q + 16'd1;
         if (err && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
      end
   end

   assign sym_count = sym_count_q;
   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_huffman_stream_ctrl.sv
// Directed bench for huffman_stream_ctrl driving a behavioural huffman_decoder model.
module tb_huffman_stream_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] byte_in = '0;
   logic       byte_valid = 1'b0;
   logic       byte_ready;
   logic       dec_in, dec_en, dec_clr;
   logic [4:0] dec_sx;
   logic       dec_flag;
   logic [4:0] sym_out;
   logic       sym_valid;
   logic       sym_ready = 1'b1;
   logic       err;
`ifdef HUFF_CTRL_STATS_EN
   logic [15:0] sym_count;
   logic [7:0]  err_count;
`endif

   int n_vec = 0;
   int n_err = 0;
   int en_count = 0;
   int err_pulses = 0;
   logic [4:0] syms[$];
   logic noflag = 1'b0;

   always #5 clk = ~clk;

   huffman_stream_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .dec_in     (dec_in),
      .dec_en     (dec_en),
      .dec_clr    (dec_clr),
      .dec_sx     (dec_sx),
      .dec_flag   (dec_flag),
      .sym_out    (sym_out),
      .sym_valid  (sym_valid),
      .sym_ready  (sym_ready),
      .err        (err)
`ifdef HUFF_CTRL_STATS_EN
      ,
      .sym_count  (sym_count),
      .err_count  (err_count)
`endif
   );

   // Decoder model: 00=1, 01=2, 10=3, 110=4, 8-bit 0xF2..0xFF = 5..18.
   logic [7:0] dm_code = '0;
   logic [3:0] dm_len = '0;

   always @(posedge clk) begin
      if (dec_clr) begin
         dm_code <= '0;
         dm_len  <= '0;
      end else if (dec_en) begin
         dm_code <= {dm_code[6:0], dec_in};
         dm_len  <= dm_len + 4'd1;
      end
   end

   always_comb begin
      logic hit;
      hit    = 1'b0;
      dec_sx = '0;
      if (dm_len == 4'd2) begin
         if (dm_code[1:0] != 2'b11) begin
            hit    = 1'b1;
            dec_sx = 5'(dm_code[1:0]) + 5'd1;
         end
      end else if (dm_len == 4'd3) begin
         if (dm_code[2:0] == 3'b110) begin
            hit    = 1'b1;
            dec_sx = 5'd4;
         end
      end else if (dm_len == 4'd8) begin
         if (dm_code >= 8'hF2) begin
            hit    = 1'b1;
            dec_sx = 5'(dm_code - 8'hED);
         end
      end
      dec_flag = hit && !noflag;
   end

   always @(posedge clk) begin
      if (reset && sym_valid && sym_ready) syms.push_back(sym_out);
      if (dec_en) en_count <= en_count + 1;
      if (err) err_pulses <= err_pulses + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // All tasks enter and leave on a falling edge.
   task automatic do_reset();
      reset      = 1'b0;
      byte_valid = 1'b0;
      sym_ready  = 1'b1;
      noflag     = 1'b0;
      #1;
      check("rst_dec_clr", 32'(dec_clr), 1);
      check("rst_byte_ready", 32'(byte_ready), 0);
      check("rst_dec_en", 32'(dec_en), 0);
      check("rst_sym_valid", 32'(sym_valid), 0);
      check("rst_sym_out", 32'(sym_out), 0);
      check("rst_err", 32'(err), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      syms.delete();
      en_count   = 0;
      err_pulses = 0;
      #1;
      check("rel_dec_clr", 32'(dec_clr), 1);
      check("rel_byte_ready", 32'(byte_ready), 0);
      @(negedge clk);
      check("load_dec_clr", 32'(dec_clr), 0);
      check("load_byte_ready", 32'(byte_ready), 1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (!byte_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("byte_accept_in_time", 32'(n < 200), 1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic wait_syms(input int cnt);
      int k = 0;
      while (syms.size() < cnt && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("sym_count_in_time", 32'(syms.size() >= cnt), 1);
   endtask

   initial begin
      int k;
      @(negedge clk);

      // Stream 0x1B 0x00: 00|01|10|110|00|00|00 with one trailing bit.
      do_reset();
      send_byte(8'h1B);
      send_byte(8'h00);
      wait_syms(7);
      check("s1_sym0", 32'(syms[0]), 1);
      check("s1_sym1", 32'(syms[1]), 2);
      check("s1_sym2", 32'(syms[2]), 3);
      check("s1_sym3", 32'(syms[3]), 4);
      check("s1_sym4", 32'(syms[4]), 1);
      check("s1_sym5", 32'(syms[5]), 1);
      check("s1_sym6", 32'(syms[6]), 1);
      check("s1_clear_clr", 32'(dec_clr), 1);
      check("s1_clear_ready", 32'(byte_ready), 0);
      @(negedge clk);
      check("s1_last_bit_en", 32'(dec_en), 1);
      check("s1_last_bit_ready", 32'(byte_ready), 0);
      @(negedge clk);
      check("s1_check_ready", 32'(byte_ready), 0);
      @(negedge clk);
      check("s1_reload_ready", 32'(byte_ready), 1);
`ifdef HUFF_CTRL_STATS_EN
      check("s1_stat_syms", 32'(sym_count), 7);
      check("s1_stat_errs", 32'(err_count), 0);
`endif

      // Backpressure on the first symbol.
      do_reset();
      sym_ready = 1'b0;
      send_byte(8'h1B);
      k = 0;
      while (!sym_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("s2_valid_in_time", 32'(sym_valid), 1);
      for (int i = 0; i < 5; i++) begin
         check("s2_hold_valid", 32'(sym_valid), 1);
         check("s2_hold_sym", 32'(sym_out), 1);
         check("s2_hold_en", 32'(dec_en), 0);
         check("s2_hold_ready", 32'(byte_ready), 0);
         @(negedge clk);
      end
      sym_ready = 1'b1;
      wait_syms(2);
      check("s2_sym0", 32'(syms[0]), 1);
      check("s2_sym1", 32'(syms[1]), 2);

      // Starvation with 11111110 straddling two bytes.
      do_reset();
      send_byte(8'h0F);
      k = 0;
      while (!byte_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("s3_starved", 32'(byte_ready), 1);
      for (int i = 0; i < 10; i++) begin
         check("s3_gap_en", 32'(dec_en), 0);
         check("s3_gap_clr", 32'(dec_clr), 0);
         @(negedge clk);
      end
      send_byte(8'hE0);
      wait_syms(3);
      check("s3_sym0", 32'(syms[0]), 1);
      check("s3_sym1", 32'(syms[1]), 1);
      check("s3_sym2", 32'(syms[2]), 17);

      // Invalid code: decoder never flags.
      do_reset();
      noflag = 1'b1;
      send_byte(8'hFF);
      k = 0;
      while (!err && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("s4_err_seen", 32'(err), 1);
      check("s4_bits_before_err", 32'(en_count), 8);
      @(negedge clk);
      check("s4_err_once", 32'(err), 0);
      check("s4_clr_after_err", 32'(dec_clr), 1);
      @(negedge clk);
      check("s4_resume_ready", 32'(byte_ready), 1);
      check("s4_clr_single", 32'(dec_clr), 0);
      repeat (5) @(negedge clk);
      check("s4_err_pulses", 32'(err_pulses), 1);
`ifdef HUFF_CTRL_STATS_EN
      check("s4_stat_errs", 32'(err_count), 1);
`endif

      // Reset during the SHIFT of the second bit.
      do_reset();
      send_byte(8'h1B);
      @(negedge clk);
      @(negedge clk);
      check("s5_in_shift", 32'(dec_en), 1);
      do_reset();
      repeat (10) @(negedge clk);
      check("s5_no_sym", 32'(syms.size()), 0);
      check("s5_idle_ready", 32'(byte_ready), 1);
      check("s5_idle_en", 32'(dec_en), 0);
      check("s5_idle_valid", 32'(sym_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
